// File: rtl/regfile_multiport.sv
// Multi-port register file: two registered read ports, two write ports with
// write-first bypass (port B wins on same-address collision) and a pending scoreboard.
module regfile_multiport #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rd_en_1,
    input  logic [ADDR_WIDTH-1:0] read_address_1,
    output logic [DATA_WIDTH-1:0] data_out_1,
    output logic                  data_valid_1,
    output logic                  pending_1,
    input  logic                  rd_en_2,
    input  logic [ADDR_WIDTH-1:0] read_address_2,
    output logic [DATA_WIDTH-1:0] data_out_2,
    output logic                  data_valid_2,
    output logic                  pending_2,
    input  logic                  write_enable_a,
    input  logic [ADDR_WIDTH-1:0] write_address_a,
    input  logic [DATA_WIDTH-1:0] write_data_a,
    input  logic                  write_enable_b,
    input  logic [ADDR_WIDTH-1:0] write_address_b,
    input  logic [DATA_WIDTH-1:0] write_data_b,
    input  logic                  reserve_enable,
    input  logic [ADDR_WIDTH-1:0] reserve_address,
    output logic                  write_collision
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs      [DEPTH];
    logic [DATA_WIDTH-1:0] regs_next [DEPTH];
    logic [DEPTH-1:0]      pending_q;
    logic [DEPTH-1:0]      pending_next;
    logic                  write_a_eff;
    logic                  write_b_eff;
    logic                  reserve_eff;

    // With ZERO_REG set, any access to register 0 is squashed here so it never
    // changes state; reads of register 0 then naturally return 0 / not pending.
    always_comb begin
        write_a_eff = write_enable_a && !((ZERO_REG != 0) && (write_address_a == '0));
        write_b_eff = write_enable_b && !((ZERO_REG != 0) && (write_address_b == '0));
        reserve_eff = reserve_enable && !((ZERO_REG != 0) && (reserve_address == '0));
        pending_next = pending_q;
        for (int i = 0; i < DEPTH; i++) begin
            regs_next[i] = regs[i];
            if (write_a_eff && (write_address_a == ADDR_WIDTH'(i))) begin
                regs_next[i]    = write_data_a;
                pending_next[i] = 1'b0;
            end
            // Port B is applied last so it wins a same-address collision.
            if (write_b_eff && (write_address_b == ADDR_WIDTH'(i))) begin
                regs_next[i]    = write_data_b;
                pending_next[i] = 1'b0;
            end
            if (reserve_eff && (reserve_address == ADDR_WIDTH'(i))) begin
                pending_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pending_q       <= '0;
            data_out_1      <= '0;
            data_out_2      <= '0;
            pending_1       <= 1'b0;
            pending_2       <= 1'b0;
            data_valid_1    <= 1'b0;
            data_valid_2    <= 1'b0;
            write_collision <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= regs_next[i];
            end
            pending_q       <= pending_next;
            write_collision <= write_a_eff && write_b_eff && (write_address_a == write_address_b);
            data_valid_1    <= rd_en_1;
            data_valid_2    <= rd_en_2;
            // Reads see next-state contents, which gives write-first bypass.
            if (rd_en_1) begin
                data_out_1 <= regs_next[read_address_1];
                pending_1  <= pending_next[read_address_1];
            end
            if (rd_en_2) begin
                data_out_2 <= regs_next[read_address_2];
                pending_2  <= pending_next[read_address_2];
            end
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench: two instances (ZERO_REG = 0 and 1) share stimulus and are
// compared every cycle against an array-based model, plus literal spot checks.
module tb_regfile_multiport;

    logic       clock;
    logic       reset;
    logic       rd_en_1, rd_en_2;
    logic [2:0] read_address_1, read_address_2;
    logic       write_enable_a, write_enable_b;
    logic [2:0] write_address_a, write_address_b;
    logic [7:0] write_data_a, write_data_b;
    logic       reserve_enable;
    logic [2:0] reserve_address;

    logic [7:0] d1 [2];
    logic [7:0] d2 [2];
    logic       v1 [2];
    logic       v2 [2];
    logic       p1 [2];
    logic       p2 [2];
    logic       coll [2];

    logic [7:0] m_mem  [2][8];
    logic       m_pend [2][8];
    logic [7:0] exp_d1 [2];
    logic [7:0] exp_d2 [2];
    logic       exp_v1 [2];
    logic       exp_v2 [2];
    logic       exp_p1 [2];
    logic       exp_p2 [2];
    logic       exp_coll [2];

    int  checks = 0;
    int  errors = 0;
    bit  check_en = 0;

    regfile_multiport #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(0)) dut0 (
        .clock(clock), .reset(reset),
        .rd_en_1(rd_en_1), .read_address_1(read_address_1),
        .data_out_1(d1[0]), .data_valid_1(v1[0]), .pending_1(p1[0]),
        .rd_en_2(rd_en_2), .read_address_2(read_address_2),
        .data_out_2(d2[0]), .data_valid_2(v2[0]), .pending_2(p2[0]),
        .write_enable_a(write_enable_a), .write_address_a(write_address_a), .write_data_a(write_data_a),
        .write_enable_b(write_enable_b), .write_address_b(write_address_b), .write_data_b(write_data_b),
        .reserve_enable(reserve_enable), .reserve_address(reserve_address),
        .write_collision(coll[0])
    );

    regfile_multiport #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(1)) dut1 (
        .clock(clock), .reset(reset),
        .rd_en_1(rd_en_1), .read_address_1(read_address_1),
        .data_out_1(d1[1]), .data_valid_1(v1[1]), .pending_1(p1[1]),
        .rd_en_2(rd_en_2), .read_address_2(read_address_2),
        .data_out_2(d2[1]), .data_valid_2(v2[1]), .pending_2(p2[1]),
        .write_enable_a(write_enable_a), .write_address_a(write_address_a), .write_data_a(write_data_a),
        .write_enable_b(write_enable_b), .write_address_b(write_address_b), .write_data_b(write_data_b),
        .reserve_enable(reserve_enable), .reserve_address(reserve_address),
        .write_collision(coll[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
        end
    endtask

    task automatic modelReset();
        for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < 8; i++) begin
                m_mem[z][i]  = 8'h00;
                m_pend[z][i] = 1'b0;
            end
            exp_d1[z] = 8'h00; exp_d2[z] = 8'h00;
            exp_v1[z] = 1'b0;  exp_v2[z] = 1'b0;
            exp_p1[z] = 1'b0;  exp_p2[z] = 1'b0;
            exp_coll[z] = 1'b0;
        end
    endtask

    // Apply the register-file rules for one clock edge, in plain sequential order.
    task automatic modelEdge();
        bit wa, wb, rs;
        for (int z = 0; z < 2; z++) begin
            wa = write_enable_a && !(z == 1 && write_address_a == 3'd0);
            wb = write_enable_b && !(z == 1 && write_address_b == 3'd0);
            rs = reserve_enable && !(z == 1 && reserve_address == 3'd0);
            exp_coll[z] = wa && wb && (write_address_a == write_address_b);
            if (wa) begin m_mem[z][write_address_a] = write_data_a; m_pend[z][write_address_a] = 1'b0; end
            if (wb) begin m_mem[z][write_address_b] = write_data_b; m_pend[z][write_address_b] = 1'b0; end
            if (rs) m_pend[z][reserve_address] = 1'b1;
            exp_v1[z] = rd_en_1;
            exp_v2[z] = rd_en_2;
            if (rd_en_1) begin exp_d1[z] = m_mem[z][read_address_1]; exp_p1[z] = m_pend[z][read_address_1]; end
            if (rd_en_2) begin exp_d2[z] = m_mem[z][read_address_2]; exp_p2[z] = m_pend[z][read_address_2]; end
        end
    endtask

    task automatic idle();
        rd_en_1 = 0; rd_en_2 = 0; read_address_1 = 0; read_address_2 = 0;
        write_enable_a = 0; write_enable_b = 0; write_address_a = 0; write_address_b = 0;
        write_data_a = 0; write_data_b = 0; reserve_enable = 0; reserve_address = 0;
    endtask

    task automatic applyStimulus();
        modelEdge();
        @(posedge clock);
        #3;
    endtask

    always @(posedge clock) begin
        if (check_en) begin
            #2;
            for (int z = 0; z < 2; z++) begin
                checkOutput($sformatf("data_out_1[%0d]", z), d1[z], exp_d1[z]);
                checkOutput($sformatf("data_out_2[%0d]", z), d2[z], exp_d2[z]);
                checkOutput($sformatf("data_valid_1[%0d]", z), {7'd0, v1[z]}, {7'd0, exp_v1[z]});
                checkOutput($sformatf("data_valid_2[%0d]", z), {7'd0, v2[z]}, {7'd0, exp_v2[z]});
                checkOutput($sformatf("pending_1[%0d]", z), {7'd0, p1[z]}, {7'd0, exp_p1[z]});
                checkOutput($sformatf("pending_2[%0d]", z), {7'd0, p2[z]}, {7'd0, exp_p2[z]});
                checkOutput($sformatf("write_collision[%0d]", z), {7'd0, coll[z]}, {7'd0, exp_coll[z]});
            end
        end
    end

    initial begin
        idle();
        modelReset();
        reset = 1'b0;
        #22;
        for (int z = 0; z < 2; z++) begin
            checkOutput("reset_data_out_1", d1[z], 8'h00);
            checkOutput("reset_valid_1", {7'd0, v1[z]}, 8'h00);
            checkOutput("reset_collision", {7'd0, coll[z]}, 8'h00);
        end
        reset = 1'b1;
        check_en = 1;

        // Read every address on both ports after reset.
        for (int a = 0; a < 8; a++) begin
            idle();
            rd_en_1 = 1; rd_en_2 = 1; read_address_1 = 3'(a); read_address_2 = 3'(7 - a);
            applyStimulus();
            checkOutput("post_reset_read_data", d1[0], 8'h00);
            checkOutput("post_reset_read_valid", {7'd0, v2[0]}, 8'h01);
        end

        idle(); write_enable_a = 1; write_address_a = 3; write_data_a = 8'h5A;
        applyStimulus();
        idle(); rd_en_1 = 1; read_address_1 = 3;
        applyStimulus();
        checkOutput("write_then_read", d1[0], 8'h5A);
        checkOutput("write_then_read_valid", {7'd0, v1[0]}, 8'h01);

        idle();
        write_enable_a = 1; write_address_a = 5; write_data_a = 8'h11;
        write_enable_b = 1; write_address_b = 5; write_data_b = 8'h22;
        rd_en_2 = 1; read_address_2 = 5;
        applyStimulus();
        checkOutput("bypass_collision_data", d2[0], 8'h22);
        checkOutput("collision_pulse", {7'd0, coll[0]}, 8'h01);
        idle(); rd_en_1 = 1; read_address_1 = 5;
        applyStimulus();
        checkOutput("collision_later_read", d1[0], 8'h22);
        checkOutput("collision_cleared", {7'd0, coll[0]}, 8'h00);

        idle(); reserve_enable = 1; reserve_address = 2;
        applyStimulus();
        idle(); rd_en_1 = 1; read_address_1 = 2;
        applyStimulus();
        checkOutput("reserve_pending", {7'd0, p1[0]}, 8'h01);
        idle(); write_enable_a = 1; write_address_a = 2; write_data_a = 8'h33;
        applyStimulus();
        idle(); rd_en_1 = 1; read_address_1 = 2;
        applyStimulus();
        checkOutput("write_clears_data", d1[0], 8'h33);
        checkOutput("write_clears_pending", {7'd0, p1[0]}, 8'h00);
        idle();
        reserve_enable = 1; reserve_address = 2;
        write_enable_b = 1; write_address_b = 2; write_data_b = 8'h34;
        rd_en_1 = 1; read_address_1 = 2;
        applyStimulus();
        checkOutput("reserve_wins_pending", {7'd0, p1[0]}, 8'h01);
        checkOutput("reserve_wins_data", d1[0], 8'h34);

        // Register 0 is hardwired on dut1 only.
        idle();
        write_enable_a = 1; write_address_a = 0; write_data_a = 8'hFF;
        write_enable_b = 1; write_address_b = 0; write_data_b = 8'h44;
        reserve_enable = 1; reserve_address = 0;
        applyStimulus();
        checkOutput("zero_reg_no_collision", {7'd0, coll[1]}, 8'h00);
        checkOutput("normal_reg0_collision", {7'd0, coll[0]}, 8'h01);
        idle(); rd_en_1 = 1; read_address_1 = 0;
        applyStimulus();
        checkOutput("zero_reg_data", d1[1], 8'h00);
        checkOutput("zero_reg_pending", {7'd0, p1[1]}, 8'h00);
        checkOutput("normal_reg0_data", d1[0], 8'h44);
        checkOutput("normal_reg0_pending", {7'd0, p1[0]}, 8'h01);

        // Asynchronous reset in the middle of continuous reads.
        idle();
        write_enable_a = 1; write_address_a = 1; write_data_a = 8'h77;
        rd_en_1 = 1; rd_en_2 = 1; read_address_1 = 1; read_address_2 = 1;
        applyStimulus();
        checkOutput("pre_reset_read", d1[0], 8'h77);
        write_enable_a = 0;
        applyStimulus();
        applyStimulus();
        check_en = 0;
        reset = 1'b0;
        #1;
        for (int z = 0; z < 2; z++) begin
            checkOutput("async_reset_data_1", d1[z], 8'h00);
            checkOutput("async_reset_data_2", d2[z], 8'h00);
            checkOutput("async_reset_valid_1", {7'd0, v1[z]}, 8'h00);
            checkOutput("async_reset_valid_2", {7'd0, v2[z]}, 8'h00);
        end
        @(posedge clock);
        #1;
        checkOutput("held_reset_valid", {7'd0, v1[0]}, 8'h00);
        #4;
        reset = 1'b1;
        modelReset();
        check_en = 1;
        applyStimulus();
        checkOutput("after_reset_read_data", d1[0], 8'h00);
        checkOutput("after_reset_read_valid", {7'd0, v1[0]}, 8'h01);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rd_en_1         = 1'($urandom_range(0, 1));
            rd_en_2         = 1'($urandom_range(0, 1));
            read_address_1  = 3'($urandom_range(0, 7));
            read_address_2  = 3'($urandom_range(0, 7));
            write_enable_a  = 1'($urandom_range(0, 1));
            write_enable_b  = 1'($urandom_range(0, 1));
            write_address_a = 3'($urandom_range(0, 7));
            write_address_b = ($urandom_range(0, 3) == 0) ? write_address_a : 3'($urandom_range(0, 7));
            write_data_a    = 8'($urandom);
            write_data_b    = 8'($urandom);
            reserve_enable  = ($urandom_range(0, 3) == 0);
            reserve_address = 3'($urandom_range(0, 7));
            applyStimulus();
        end

        idle();
        check_en = 0;
        #10;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
